// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared command, branch-type and multiplier-state definitions
package mips_pkg;

    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_ADD = 4'b0001;
    localparam logic [3:0] EXE_SUB = 4'b0011;
    localparam logic [3:0] EXE_AND = 4'b0101;
    localparam logic [3:0] EXE_OR  = 4'b0110;
    localparam logic [3:0] EXE_NOR = 4'b0111;
    localparam logic [3:0] EXE_XOR = 4'b1000;
    localparam logic [3:0] EXE_SLL = 4'b1001;
    localparam logic [3:0] EXE_SRA = 4'b1010;
    localparam logic [3:0] EXE_SRL = 4'b1011;
    localparam logic [3:0] EXE_MUL = 4'b1100;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEZ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_JMP  = 2'b11;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_e;

endpackage

// File: rtl/exe_stage_if.sv
// rtl/exe_stage_if.sv - ID/EX input bundle and EX/MEM output bundle of the execute stage
interface exe_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CMD_W  = 4
);
    logic [REG_AW-1:0] dest_in;
    logic [DATA_W-1:0] reg1_in;
    logic [DATA_W-1:0] reg2_in;
    logic [DATA_W-1:0] imm_in;
    logic [DATA_W-1:0] pc_in;
    logic [1:0]        branch_type_in;
    logic [CMD_W-1:0]  exe_cmd_in;
    logic              mem_r_en_in;
    logic              mem_w_en_in;
    logic              wb_en_in;

    logic              stall_o;
    logic              br_taken_o;
    logic [DATA_W-1:0] br_addr_o;
    logic [DATA_W-1:0] alu_result_o;
    logic [DATA_W-1:0] st_val_o;
    logic [REG_AW-1:0] dest_o;
    logic              mem_r_en_o;
    logic              mem_w_en_o;
    logic              wb_en_o;

    // master is the upstream/downstream pipeline side, slave is the execute stage
    modport master (
        output dest_in, reg1_in, reg2_in, imm_in, pc_in, branch_type_in,
               exe_cmd_in, mem_r_en_in, mem_w_en_in, wb_en_in,
        input  stall_o, br_taken_o, br_addr_o, alu_result_o, st_val_o,
               dest_o, mem_r_en_o, mem_w_en_o, wb_en_o
    );

    modport slave (
        input  dest_in, reg1_in, reg2_in, imm_in, pc_in, branch_type_in,
               exe_cmd_in, mem_r_en_in, mem_w_en_in, wb_en_in,
        output stall_o, br_taken_o, br_addr_o, alu_result_o, st_val_o,
               dest_o, mem_r_en_o, mem_w_en_o, wb_en_o
    );
endinterface

// File: rtl/iter_mul.sv
// rtl/iter_mul.sv - iterative shift-add multiplier, one partial product per cycle
module iter_mul
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);
    localparam int CNT_W = $clog2(DATA_W);

    mul_state_e        state_q;
    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [DATA_W-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MUL_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                MUL_IDLE: begin
                    if (start) begin
                        mcand_q  <= a;
                        mplier_q <= b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_q <= MUL_DONE;
                    end
                end
                // Unconditional return so a MUL still held on the inputs is not restarted
                MUL_DONE: state_q <= MUL_IDLE;
                default:  state_q <= MUL_IDLE;
            endcase
        end
    end

    assign busy    = (state_q == MUL_BUSY) || ((state_q == MUL_IDLE) && start);
    assign done    = (state_q == MUL_DONE);
    assign product = acc_q;

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - MIPS execute stage: ALU, branch resolution, multiplier and EX/MEM register
module exe_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CMD_W  = 4
) (
    input  logic        clk,
    input  logic        rst,
    exe_stage_if.slave  bus
);
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_res;
    logic              mul_busy;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;
    logic              stall;
    logic              br_cond;

    logic [DATA_W-1:0] alu_result_d, alu_result_q;
    logic [DATA_W-1:0] st_val_d,     st_val_q;
    logic [REG_AW-1:0] dest_d,       dest_q;
    logic              mem_r_en_d,   mem_r_en_q;
    logic              mem_w_en_d,   mem_w_en_q;
    logic              wb_en_d,      wb_en_q;

    assign op_a = bus.reg1_in;
    assign op_b = bus.imm_in;

    iter_mul #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (bus.exe_cmd_in == CMD_W'(EXE_MUL)),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Reset must drop the stall at once even if a MUL is still presented
    assign stall = mul_busy & ~rst;

    always_comb begin
        alu_res = '0;
        case (bus.exe_cmd_in)
            CMD_W'(EXE_ADD): alu_res = op_a + op_b;
            CMD_W'(EXE_SUB): alu_res = op_a - op_b;
            CMD_W'(EXE_AND): alu_res = op_a & op_b;
            CMD_W'(EXE_OR):  alu_res = op_a | op_b;
            CMD_W'(EXE_NOR): alu_res = ~(op_a | op_b);
            CMD_W'(EXE_XOR): alu_res = op_a ^ op_b;
            CMD_W'(EXE_SLL): alu_res = op_a << op_b[4:0];
            CMD_W'(EXE_SRA): alu_res = DATA_W'($signed(op_a) >>> op_b[4:0]);
            CMD_W'(EXE_SRL): alu_res = op_a >> op_b[4:0];
            CMD_W'(EXE_MUL): alu_res = mul_done ? mul_product : '0;
            default:         alu_res = '0;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (bus.branch_type_in)
            BR_BEZ:  br_cond = (bus.reg1_in == '0);
            BR_BNE:  br_cond = (bus.reg1_in != bus.reg2_in);
            BR_JMP:  br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
    end

    assign bus.br_taken_o = br_cond & ~stall;
    assign bus.br_addr_o  = bus.pc_in + (bus.imm_in << 2);
    assign bus.stall_o    = stall;

    // A stalled cycle inserts an all-zero bubble into EX/MEM
    always_comb begin
        alu_result_d = '0;
        st_val_d     = '0;
        dest_d       = '0;
        mem_r_en_d   = 1'b0;
        mem_w_en_d   = 1'b0;
        wb_en_d      = 1'b0;
        if (!stall) begin
            alu_result_d = alu_res;
            st_val_d     = bus.reg2_in;
            dest_d       = bus.dest_in;
            mem_r_en_d   = bus.mem_r_en_in;
            mem_w_en_d   = bus.mem_w_en_in;
            wb_en_d      = bus.wb_en_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result_q <= '0;
            st_val_q     <= '0;
            dest_q       <= '0;
            mem_r_en_q   <= 1'b0;
            mem_w_en_q   <= 1'b0;
            wb_en_q      <= 1'b0;
        end else begin
            alu_result_q <= alu_result_d;
            st_val_q     <= st_val_d;
            dest_q       <= dest_d;
            mem_r_en_q   <= mem_r_en_d;
            mem_w_en_q   <= mem_w_en_d;
            wb_en_q      <= wb_en_d;
        end
    end

    assign bus.alu_result_o = alu_result_q;
    assign bus.st_val_o     = st_val_q;
    assign bus.dest_o       = dest_q;
    assign bus.mem_r_en_o   = mem_r_en_q;
    assign bus.mem_w_en_o   = mem_w_en_q;
    assign bus.wb_en_o      = wb_en_q;

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - directed self-checking bench for exe_stage
module tb_exe_stage;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    exe_stage_if #(.DATA_W(32), .REG_AW(5), .CMD_W(4)) bus ();

    exe_stage #(.DATA_W(32), .REG_AW(5), .CMD_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r2, input logic [31:0] pc, input logic [1:0] bt,
                         input logic [4:0] dest, input logic r, input logic w, input logic wb);
        bus.exe_cmd_in     = cmd;
        bus.reg1_in        = a;
        bus.imm_in         = b;
        bus.reg2_in        = r2;
        bus.pc_in          = pc;
        bus.branch_type_in = bt;
        bus.dest_in        = dest;
        bus.mem_r_en_in    = r;
        bus.mem_w_en_in    = w;
        bus.wb_en_in       = wb;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'b0000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        #12;
        checks++;
        if (bus.stall_o !== 1'b0 || bus.br_taken_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl stall=%b br_taken=%b required 0 0", bus.stall_o, bus.br_taken_o);
        end
        checks++;
        if (bus.alu_result_o !== 32'h0 || bus.st_val_o !== 32'h0 || bus.dest_o !== 5'h0 ||
            bus.mem_r_en_o !== 1'b0 || bus.mem_w_en_o !== 1'b0 || bus.wb_en_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs alu=%h st=%h dest=%h r=%b w=%b wb=%b required all 0",
                     bus.alu_result_o, bus.st_val_o, bus.dest_o, bus.mem_r_en_o, bus.mem_w_en_o, bus.wb_en_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_add();
        drive(4'b0001, 5, 7, 32'hCAFE, 0, 2'b00, 3, 0, 0, 1);
        #1;
        checks++;
        if (bus.stall_o !== 1'b0) begin
            errors++;
            $display("FAIL add_stall got %b required 0", bus.stall_o);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.alu_result_o !== 32'd12 || bus.wb_en_o !== 1'b1 || bus.dest_o !== 5'd3 ||
            bus.st_val_o !== 32'hCAFE || bus.stall_o !== 1'b0) begin
            errors++;
            $display("FAIL add alu=%h wb=%b dest=%h st=%h stall=%b required 0000000c 1 03 0000cafe 0",
                     bus.alu_result_o, bus.wb_en_o, bus.dest_o, bus.st_val_o, bus.stall_o);
        end
    endtask

    task automatic test_alu();
        logic [3:0]  cmds [12] = '{4'b0011, 4'b1010, 4'b1011, 4'b0101, 4'b0110, 4'b0111,
                                   4'b1000, 4'b1001, 4'b1001, 4'b0001, 4'b0010, 4'b0000};
        logic [31:0] as   [12] = '{32'd3, 32'h80000000, 32'h80000000, 32'hF0F0, 32'hF0F0, 32'h0,
                                   32'hFF00, 32'h1, 32'h1, 32'hFFFFFFFF, 32'd5, 32'd5};
        logic [31:0] bs   [12] = '{32'd5, 32'd4, 32'd4, 32'hFF00, 32'h0F00, 32'h0,
                                   32'h0FF0, 32'd31, 32'd33, 32'd1, 32'd7, 32'd7};
        logic [31:0] exps [12] = '{32'hFFFFFFFE, 32'hF8000000, 32'h08000000, 32'h0000F000,
                                   32'h0000FFF0, 32'hFFFFFFFF, 32'h0000F0F0, 32'h80000000,
                                   32'h00000002, 32'h00000000, 32'h00000000, 32'h00000000};
        for (int i = 0; i < 12; i++) begin
            drive(cmds[i], as[i], bs[i], 32'h100 + i, 0, 2'b00, 5'(i + 1), 1'b0, i[0], 1'b1);
            @(posedge clk); #1;
            checks++;
            if (bus.alu_result_o !== exps[i] || bus.mem_w_en_o !== i[0] || bus.st_val_o !== 32'h100 + i) begin
                errors++;
                $display("FAIL alu_vec%0d cmd=%b alu=%h memw=%b st=%h required %h %b %h",
                         i, cmds[i], bus.alu_result_o, bus.mem_w_en_o, bus.st_val_o,
                         exps[i], i[0], 32'h100 + i);
            end
        end
    endtask

    task automatic test_branch();
        drive(4'b0000, 1, 3, 2, 32'h100, 2'b10, 0, 0, 0, 0);
        #1;
        checks++;
        if (bus.br_taken_o !== 1'b1 || bus.br_addr_o !== 32'h10C) begin
            errors++;
            $display("FAIL bne_taken taken=%b addr=%h required 1 0000010c", bus.br_taken_o, bus.br_addr_o);
        end
        drive(4'b0000, 4, 3, 4, 32'h100, 2'b10, 0, 0, 0, 0);
        #1;
        checks++;
        if (bus.br_taken_o !== 1'b0) begin
            errors++;
            $display("FAIL bne_equal taken=%b required 0", bus.br_taken_o);
        end
        drive(4'b0000, 4, 3, 0, 32'h100, 2'b01, 0, 0, 0, 0);
        #1;
        checks++;
        if (bus.br_taken_o !== 1'b0) begin
            errors++;
            $display("FAIL bez_nonzero taken=%b required 0", bus.br_taken_o);
        end
        drive(4'b0000, 0, 32'hFFFFFFFF, 0, 32'h200, 2'b01, 0, 0, 0, 0);
        #1;
        checks++;
        if (bus.br_taken_o !== 1'b1 || bus.br_addr_o !== 32'h1FC) begin
            errors++;
            $display("FAIL bez_zero taken=%b addr=%h required 1 000001fc", bus.br_taken_o, bus.br_addr_o);
        end
        drive(4'b0000, 7, 1, 7, 32'h40, 2'b11, 0, 0, 0, 0);
        #1;
        checks++;
        if (bus.br_taken_o !== 1'b1 || bus.br_addr_o !== 32'h44) begin
            errors++;
            $display("FAIL jmp taken=%b addr=%h required 1 00000044", bus.br_taken_o, bus.br_addr_o);
        end
        drive(4'b0000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        @(posedge clk); #1;
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp, input string nm);
        int n;
        int bad;
        n   = 0;
        bad = 0;
        drive(4'b1100, a, b, 0, 0, 2'b00, 5'd9, 0, 0, 1);
        #1;
        while (bus.stall_o === 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (bus.wb_en_o !== 1'b0) bad++;
        end
        checks++;
        if (n != 33) begin
            errors++;
            $display("FAIL %s_stall_cycles got %0d required 33", nm, n);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_bubbles wb_en_o high on %0d stalled edges required 0", nm, bad);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.alu_result_o !== exp || bus.wb_en_o !== 1'b1 || bus.dest_o !== 5'd9) begin
            errors++;
            $display("FAIL %s_result alu=%h wb=%b dest=%h required %h 1 09", nm,
                     bus.alu_result_o, bus.wb_en_o, bus.dest_o, exp);
        end
        drive(4'b0000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        run_mul(32'h1234, 32'h10, 32'h00012340, "mul_small");
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "mul_ones");
        run_mul(32'h0, 32'hDEADBEEF, 32'h00000000, "mul_zero");
    endtask

    task automatic test_back_to_back();
        int n;
        n = 0;
        drive(4'b1100, 6, 7, 0, 0, 2'b00, 5'd4, 0, 0, 1);
        #1;
        while (bus.stall_o === 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        checks++;
        if (bus.alu_result_o !== 32'd42 || bus.wb_en_o !== 1'b1 || bus.dest_o !== 5'd4) begin
            errors++;
            $display("FAIL b2b_first alu=%h wb=%b dest=%h required 0000002a 1 04",
                     bus.alu_result_o, bus.wb_en_o, bus.dest_o);
        end
        drive(4'b1100, 3, 3, 0, 0, 2'b00, 5'd6, 0, 0, 1);
        #1;
        n = 0;
        while (bus.stall_o === 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                checks++;
                if (bus.wb_en_o !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_no_dup wb=%b required 0", bus.wb_en_o);
                end
            end
        end
        @(posedge clk); #1;
        n++;
        checks++;
        if (n != 34 || bus.alu_result_o !== 32'd9 || bus.wb_en_o !== 1'b1 || bus.dest_o !== 5'd6) begin
            errors++;
            $display("FAIL b2b_second gap=%0d alu=%h wb=%b dest=%h required 34 00000009 1 06",
                     n, bus.alu_result_o, bus.wb_en_o, bus.dest_o);
        end
        drive(4'b0000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_mul();
        drive(4'b1100, 32'h55, 3, 32'h77, 0, 2'b00, 5'd2, 1, 1, 1);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.stall_o !== 1'b0 || bus.alu_result_o !== 32'h0 || bus.wb_en_o !== 1'b0 ||
            bus.dest_o !== 5'h0 || bus.st_val_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_mul stall=%b alu=%h wb=%b dest=%h st=%h required 0 0 0 0 0",
                     bus.stall_o, bus.alu_result_o, bus.wb_en_o, bus.dest_o, bus.st_val_o);
        end
        drive(4'b0001, 1, 1, 0, 0, 2'b00, 5'd5, 0, 0, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.stall_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_release_stall got %b required 0", bus.stall_o);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.alu_result_o !== 32'd2 || bus.wb_en_o !== 1'b1 || bus.dest_o !== 5'd5 || bus.stall_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_then_add alu=%h wb=%b dest=%h stall=%b required 00000002 1 05 0",
                     bus.alu_result_o, bus.wb_en_o, bus.dest_o, bus.stall_o);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_add();
        test_alu();
        test_branch();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
